// File: rtl/lcd_pkg.sv
// Shared constants for the LCD controller: bus register map, command opcodes,
// reset contrast and the command decoder state type.
package lcd_pkg;

    localparam logic [23:0] REG_CMD  = 24'h0020FE;
    localparam logic [23:0] REG_DATA = 24'h0020FF;

    // Range opcodes are matched on their prefix; the remaining bits carry the operand.
    localparam logic [3:0] OP_COL_LO_NIB     = 4'h0;
    localparam logic [3:0] OP_COL_HI_NIB     = 4'h1;
    localparam logic [3:0] OP_PAGE_NIB       = 4'hB;
    localparam logic [1:0] OP_START_LINE_PFX = 2'b01;

    localparam logic [7:0] OP_CONTRAST    = 8'h81;
    localparam logic [7:0] OP_DISPLAY_OFF = 8'hAE;
    localparam logic [7:0] OP_DISPLAY_ON  = 8'hAF;
    localparam logic [7:0] OP_NORMAL      = 8'hA6;
    localparam logic [7:0] OP_REVERSE     = 8'hA7;
    localparam logic [7:0] OP_ALL_OFF     = 8'hA4;
    localparam logic [7:0] OP_ALL_ON      = 8'hA5;
    localparam logic [7:0] OP_SOFT_RESET  = 8'hE2;
    localparam logic [7:0] OP_RMW_START   = 8'hE0;
    localparam logic [7:0] OP_RMW_END     = 8'hEE;

    localparam logic [5:0] CONTRAST_RESET = 6'h20;

    typedef enum logic {
        CMD_IDLE,
        CMD_CONTRAST
    } cmd_state_e;

endpackage

// File: rtl/lcd_ram.sv
// Display RAM, NUM_PAGES x NUM_COLUMNS bytes, true dual-port with registered reads.
// Port A is the bus side (read/write), port B the scan-out side (read only).
module lcd_ram #(
    parameter int NUM_COLUMNS = 132,
    parameter int NUM_PAGES   = 9
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       a_we_i,
    input  logic       a_re_i,
    input  logic [3:0] a_page_i,
    input  logic [7:0] a_col_i,
    input  logic [7:0] a_wdata_i,
    output logic [7:0] a_rdata_o,
    input  logic [3:0] b_page_i,
    input  logic [7:0] b_col_i,
    output logic [7:0] b_rdata_o
);

    localparam int DEPTH = NUM_PAGES * NUM_COLUMNS;
    localparam int AW    = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic          aValid;
    logic          bValid;
    logic [AW-1:0] aAddr;
    logic [AW-1:0] bAddr;
    logic [7:0]    aRdata_q;
    logic [7:0]    bRdata_q;

    assign aValid = (int'(a_page_i) < NUM_PAGES) && (int'(a_col_i) < NUM_COLUMNS);
    assign bValid = (int'(b_page_i) < NUM_PAGES) && (int'(b_col_i) < NUM_COLUMNS);
    assign aAddr  = AW'(int'(a_page_i) * NUM_COLUMNS + int'(a_col_i));
    assign bAddr  = AW'(int'(b_page_i) * NUM_COLUMNS + int'(b_col_i));

    always_ff @(posedge clk) begin
        if (a_we_i && aValid) begin
            mem[aAddr] <= a_wdata_i;
        end
    end

    // Reads sample the array before this edge's write lands, so a collision returns the old byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aRdata_q <= 8'h00;
            bRdata_q <= 8'h00;
        end else begin
            if (a_re_i) begin
                aRdata_q <= aValid ? mem[aAddr] : 8'h00;
            end
            bRdata_q <= bValid ? mem[bAddr] : 8'h00;
        end
    end

    assign a_rdata_o = aRdata_q;
    assign b_rdata_o = bRdata_q;

endmodule

// File: rtl/lcd_controller.sv
// LCD controller: command/data bus decoder, mode registers and display RAM.
// Define LCD_READ_MODIFY_WRITE_EN to enable the 0xE0/0xEE read-modify-write column mode.
import lcd_pkg::*;

module lcd_controller #(
    parameter int NUM_COLUMNS = 132,
    parameter int NUM_PAGES   = 9
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [23:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    input  logic [3:0]  vid_page,
    input  logic [7:0]  vid_column,
    output logic [7:0]  vid_data,
    output logic        display_on,
    output logic        reverse,
    output logic        all_on,
    output logic [5:0]  contrast,
    output logic [5:0]  start_line
);

    localparam logic [7:0] COL_LAST = 8'(NUM_COLUMNS - 1);

    cmd_state_e state_q;
    logic [7:0] column_q;
    logic [7:0] colInc_d;
    logic [3:0] page_q;
    logic [5:0] startLine_q;
    logic [5:0] contrast_q;
    logic       displayOn_q;
    logic       reverse_q;
    logic       allOn_q;
    logic       stale_q;
    logic       resetBusy_q;
    logic       cmdWr;
    logic       datWr;
    logic       datRd;
    logic [7:0] latchData;
`ifdef LCD_READ_MODIFY_WRITE_EN
    logic       rmw_q;
    logic [7:0] savedCol_q;
`endif

    assign cmdWr = bus_write && (bus_address_in == REG_CMD);
    assign datWr = bus_write && (bus_address_in == REG_DATA);
    assign datRd = bus_read && !bus_write && (bus_address_in == REG_DATA);

    // Column stops at the last column; a column set beyond range by command is left alone.
    assign colInc_d = (column_q < COL_LAST) ? column_q + 8'd1 : column_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CMD_IDLE;
            column_q    <= 8'h00;
            page_q      <= 4'h0;
            startLine_q <= 6'h00;
            contrast_q  <= CONTRAST_RESET;
            displayOn_q <= 1'b0;
            reverse_q   <= 1'b0;
            allOn_q     <= 1'b0;
            stale_q     <= 1'b1;
            resetBusy_q <= 1'b0;
`ifdef LCD_READ_MODIFY_WRITE_EN
            rmw_q       <= 1'b0;
            savedCol_q  <= 8'h00;
`endif
        end else begin
            resetBusy_q <= 1'b0;
            if (cmdWr) begin
                if (state_q == CMD_CONTRAST) begin
                    contrast_q <= bus_data_in[5:0];
                    state_q    <= CMD_IDLE;
                end else if (bus_data_in[7:4] == OP_COL_LO_NIB) begin
                    column_q[3:0] <= bus_data_in[3:0];
                    stale_q       <= 1'b1;
                end else if (bus_data_in[7:4] == OP_COL_HI_NIB) begin
                    column_q[7:4] <= bus_data_in[3:0];
                    stale_q       <= 1'b1;
                end else if (bus_data_in[7:4] == OP_PAGE_NIB) begin
                    page_q  <= bus_data_in[3:0];
                    stale_q <= 1'b1;
                end else if (bus_data_in[7:6] == OP_START_LINE_PFX) begin
                    startLine_q <= bus_data_in[5:0];
                end else begin
                    case (bus_data_in)
                        OP_CONTRAST:    state_q     <= CMD_CONTRAST;
                        OP_DISPLAY_OFF: displayOn_q <= 1'b0;
                        OP_DISPLAY_ON:  displayOn_q <= 1'b1;
                        OP_NORMAL:      reverse_q   <= 1'b0;
                        OP_REVERSE:     reverse_q   <= 1'b1;
                        OP_ALL_OFF:     allOn_q     <= 1'b0;
                        OP_ALL_ON:      allOn_q     <= 1'b1;
                        OP_SOFT_RESET: begin
                            column_q    <= 8'h00;
                            page_q      <= 4'h0;
                            startLine_q <= 6'h00;
                            contrast_q  <= CONTRAST_RESET;
                            displayOn_q <= 1'b0;
                            reverse_q   <= 1'b0;
                            allOn_q     <= 1'b0;
                            stale_q     <= 1'b1;
                            resetBusy_q <= 1'b1;
`ifdef LCD_READ_MODIFY_WRITE_EN
                            rmw_q       <= 1'b0;
`endif
                        end
`ifdef LCD_READ_MODIFY_WRITE_EN
                        OP_RMW_START: begin
                            savedCol_q <= column_q;
                            rmw_q      <= 1'b1;
                        end
                        OP_RMW_END: begin
                            column_q <= savedCol_q;
                            rmw_q    <= 1'b0;
                            stale_q  <= 1'b1;
                        end
`else
                        OP_RMW_START, OP_RMW_END: ;
`endif
                        default: ;
                    endcase
                end
            end else if (datWr) begin
                column_q <= colInc_d;
            end else if (datRd) begin
                stale_q <= 1'b0;
`ifdef LCD_READ_MODIFY_WRITE_EN
                column_q <= rmw_q ? column_q : colInc_d;
`else
                column_q <= colInc_d;
`endif
            end
        end
    end

    lcd_ram #(
        .NUM_COLUMNS(NUM_COLUMNS),
        .NUM_PAGES  (NUM_PAGES)
    ) u_ram (
        .clk      (clk),
        .reset_n  (reset_n),
        .a_we_i   (datWr),
        .a_re_i   (datRd),
        .a_page_i (page_q),
        .a_col_i  (column_q),
        .a_wdata_i(bus_data_in),
        .a_rdata_o(latchData),
        .b_page_i (vid_page),
        .b_col_i  (vid_column),
        .b_rdata_o(vid_data)
    );

    // The RAM's port-A output register doubles as the dummy-read latch.
    always_comb begin
        bus_data_out = 8'h00;
        if (reset_n) begin
            if (bus_address_in == REG_CMD) begin
                bus_data_out = {2'b00, ~displayOn_q, resetBusy_q, 4'h0};
            end else if (bus_address_in == REG_DATA) begin
                bus_data_out = stale_q ? 8'h00 : latchData;
            end
        end
    end

    assign display_on = displayOn_q;
    assign reverse    = reverse_q;
    assign all_on     = allOn_q;
    assign contrast   = contrast_q;
    assign start_line = startLine_q;

endmodule

// File: tb/tb_lcd_controller.sv
// Self-checking bench for lcd_controller; expected values are queued as stimulus is applied.
module tb_lcd_controller;

    logic        clk;
    logic        reset_n;
    logic        bus_write;
    logic        bus_read;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic [3:0]  vid_page;
    logic [7:0]  vid_column;
    logic [7:0]  vid_data;
    logic        display_on;
    logic        reverse;
    logic        all_on;
    logic [5:0]  contrast;
    logic [5:0]  start_line;

    logic [7:0]  expQ[$];
    logic [7:0]  got;
    logic [7:0]  exp;
    int          compared;
    int          mismatched;

    lcd_controller dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus_write     (bus_write),
        .bus_read      (bus_read),
        .bus_address_in(bus_address_in),
        .bus_data_in   (bus_data_in),
        .bus_data_out  (bus_data_out),
        .vid_page      (vid_page),
        .vid_column    (vid_column),
        .vid_data      (vid_data),
        .display_on    (display_on),
        .reverse       (reverse),
        .all_on        (all_on),
        .contrast      (contrast),
        .start_line    (start_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers all start and end 1 ns after a rising edge.
    task automatic applyCmd(input logic [7:0] d);
        bus_address_in = 24'h0020FE;
        bus_data_in    = d;
        bus_write      = 1'b1;
        @(posedge clk);
        #1;
        bus_write = 1'b0;
    endtask

    task automatic applyData(input logic [7:0] d);
        bus_address_in = 24'h0020FF;
        bus_data_in    = d;
        bus_write      = 1'b1;
        @(posedge clk);
        #1;
        bus_write = 1'b0;
    endtask

    task automatic applyRead(output logic [7:0] v);
        bus_address_in = 24'h0020FF;
        bus_read       = 1'b1;
        #1;
        v = bus_data_out;
        @(posedge clk);
        #1;
        bus_read = 1'b0;
    endtask

    task automatic applyVidRead(input logic [3:0] p, input logic [7:0] c, output logic [7:0] v);
        vid_page   = p;
        vid_column = c;
        @(posedge clk);
        #1;
        v = vid_data;
    endtask

    task automatic test_reset;
        reset_n        = 1'b0;
        bus_address_in = 24'h0020FE;
        #3;
        expQ.push_back(8'h00);
        got = bus_data_out; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL rst_bus_out: got %h expected %h", got, exp); end
        expQ.push_back(8'h00);
        got = vid_data; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL rst_vid_data: got %h expected %h", got, exp); end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        expQ.push_back(8'h20);
        got = bus_data_out; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL rst_status: got %h expected %h", got, exp); end
        expQ.push_back(8'h20);
        got = {2'b00, contrast}; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL rst_contrast: got %h expected %h", got, exp); end
        expQ.push_back(8'h00);
        got = {2'b00, start_line}; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL rst_start_line: got %h expected %h", got, exp); end
        expQ.push_back(8'h00);
        got = {5'b0, display_on, reverse, all_on}; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL rst_flags: got %h expected %h", got, exp); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_basic;
        applyCmd(8'h10); applyCmd(8'h00); applyCmd(8'hB0);
        applyData(8'hA5); expQ.push_back(8'hA5);
        applyData(8'h5A); expQ.push_back(8'h5A);
        applyData(8'h33); expQ.push_back(8'h33);
        for (int c = 0; c < 3; c++) begin
            applyVidRead(4'd0, 8'(c), got);
            exp = expQ.pop_front(); compared++;
            if (got !== exp) begin mismatched++; $display("[TB] FAIL wb_vid_col%0d: got %h expected %h", c, got, exp); end
        end
        applyCmd(8'h00);
        expQ.push_back(8'h00); expQ.push_back(8'hA5); expQ.push_back(8'h5A);
        for (int r = 0; r < 3; r++) begin
            applyRead(got);
            exp = expQ.pop_front(); compared++;
            if (got !== exp) begin mismatched++; $display("[TB] FAIL wb_read%0d: got %h expected %h", r, got, exp); end
        end
    endtask

    task automatic test_saturate;
        applyCmd(8'h18); applyCmd(8'h03);
        applyData(8'h11); applyData(8'h22); expQ.push_back(8'h22);
        applyVidRead(4'd0, 8'd131, got);
        exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL sat_last_col: got %h expected %h", got, exp); end
        applyData(8'h44); expQ.push_back(8'h44);
        applyVidRead(4'd0, 8'd131, got);
        exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL sat_stays: got %h expected %h", got, exp); end
        expQ.push_back(8'h00);
        applyVidRead(4'd0, 8'd132, got);
        exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL vid_col_range: got %h expected %h", got, exp); end
        expQ.push_back(8'h00);
        applyVidRead(4'd9, 8'd0, got);
        exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL vid_page_range: got %h expected %h", got, exp); end
    endtask

    task automatic test_dropped_page;
        applyCmd(8'hB9); applyCmd(8'h00); applyCmd(8'h10);
        applyData(8'h66);
        applyCmd(8'hB0);
        applyData(8'h77); expQ.push_back(8'h77); expQ.push_back(8'hA5);
        applyVidRead(4'd0, 8'd1, got);
        exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL drop_col_inc: got %h expected %h", got, exp); end
        applyVidRead(4'd0, 8'd0, got);
        exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL drop_no_alias: got %h expected %h", got, exp); end
    endtask

    task automatic test_contrast;
        applyCmd(8'h81); applyCmd(8'h3F); expQ.push_back(8'h3F);
        got = {2'b00, contrast}; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL contrast_load: got %h expected %h", got, exp); end
        applyCmd(8'h81); applyData(8'h77); expQ.push_back(8'h3F);
        got = {2'b00, contrast}; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL contrast_data_hold: got %h expected %h", got, exp); end
        applyCmd(8'h05); expQ.push_back(8'h05);
        got = {2'b00, contrast}; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL contrast_still_armed: got %h expected %h", got, exp); end
        applyCmd(8'h05); expQ.push_back(8'h05);
        got = {2'b00, contrast}; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL contrast_back_idle: got %h expected %h", got, exp); end
    endtask

    task automatic test_modes;
        applyCmd(8'hA7); applyCmd(8'hA5); applyCmd(8'hAF); applyCmd(8'h5A);
        expQ.push_back(8'h07); expQ.push_back(8'h1A); expQ.push_back(8'h00);
        got = {5'b0, display_on, reverse, all_on}; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL modes_set: got %h expected %h", got, exp); end
        got = {2'b00, start_line}; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL start_line: got %h expected %h", got, exp); end
        bus_address_in = 24'h0020FE;
        #1;
        got = bus_data_out; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL status_on: got %h expected %h", got, exp); end
        applyCmd(8'hA6); applyCmd(8'hA4); expQ.push_back(8'h04);
        got = {5'b0, display_on, reverse, all_on}; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL modes_clear: got %h expected %h", got, exp); end
    endtask

    task automatic test_read_latch;
        applyCmd(8'hB2); applyCmd(8'h05); applyCmd(8'h10);
        applyData(8'hC3);
        applyCmd(8'hB2); applyCmd(8'h05); applyCmd(8'h10);
        expQ.push_back(8'h00); expQ.push_back(8'hC3);
        applyRead(got);
        exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL read_dummy: got %h expected %h", got, exp); end
        applyRead(got);
        exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL read_value: got %h expected %h", got, exp); end
    endtask

    task automatic test_soft_reset;
        applyCmd(8'hAF); applyCmd(8'hE2);
        expQ.push_back(8'h30); expQ.push_back(8'h20);
        bus_address_in = 24'h0020FE;
        #1;
        got = bus_data_out; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL sr_busy: got %h expected %h", got, exp); end
        @(posedge clk);
        #1;
        got = bus_data_out; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL sr_busy_clear: got %h expected %h", got, exp); end
        bus_address_in = 24'h0020FF;
        expQ.push_back(8'h00); expQ.push_back(8'h00); expQ.push_back(8'h20);
        #1;
        got = bus_data_out; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL sr_latch_stale: got %h expected %h", got, exp); end
        got = {5'b0, display_on, reverse, all_on}; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL sr_flags: got %h expected %h", got, exp); end
        got = {2'b00, contrast}; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL sr_contrast: got %h expected %h", got, exp); end
        expQ.push_back(8'hC3);
        applyVidRead(4'd2, 8'd5, got);
        exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL sr_ram_kept: got %h expected %h", got, exp); end
        applyData(8'hEE); expQ.push_back(8'hEE);
        applyVidRead(4'd0, 8'd0, got);
        exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL sr_addr_zero: got %h expected %h", got, exp); end
    endtask

    task automatic test_reset_mid_command;
        applyCmd(8'h81);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyCmd(8'h05); expQ.push_back(8'h20); expQ.push_back(8'hC3);
        got = {2'b00, contrast}; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL mid_reset_contrast: got %h expected %h", got, exp); end
        applyVidRead(4'd2, 8'd5, got);
        exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL mid_reset_ram: got %h expected %h", got, exp); end
    endtask

    task automatic test_collision;
        applyCmd(8'hB1); applyCmd(8'h00); applyCmd(8'h10);
        applyData(8'h11);
        applyCmd(8'h00);
        expQ.push_back(8'h11); expQ.push_back(8'h99);
        vid_page       = 4'd1;
        vid_column     = 8'd0;
        bus_address_in = 24'h0020FF;
        bus_data_in    = 8'h99;
        bus_write      = 1'b1;
        @(posedge clk);
        #1;
        bus_write = 1'b0;
        got = vid_data; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL collide_old: got %h expected %h", got, exp); end
        @(posedge clk);
        #1;
        got = vid_data; exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL collide_new: got %h expected %h", got, exp); end
    endtask

    task automatic test_rmw;
        logic [7:0] dummy;
        applyCmd(8'hB0); applyCmd(8'h0A); applyCmd(8'h10);
        applyCmd(8'hE0);
        applyRead(dummy);
        applyRead(dummy);
        applyData(8'h55);
`ifdef LCD_READ_MODIFY_WRITE_EN
        expQ.push_back(8'h55);
        applyVidRead(4'd0, 8'd10, got);
        exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL rmw_write_col: got %h expected %h", got, exp); end
        applyCmd(8'hEE);
        applyData(8'hAB); applyData(8'hCD);
        expQ.push_back(8'hAB); expQ.push_back(8'hCD);
        applyVidRead(4'd0, 8'd10, got);
        exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL rmw_restore: got %h expected %h", got, exp); end
        applyVidRead(4'd0, 8'd11, got);
        exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL rmw_next: got %h expected %h", got, exp); end
`else
        applyCmd(8'hEE);
        applyData(8'h66);
        expQ.push_back(8'h55); expQ.push_back(8'h66);
        applyVidRead(4'd0, 8'd12, got);
        exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL norm_read_inc: got %h expected %h", got, exp); end
        applyVidRead(4'd0, 8'd13, got);
        exp = expQ.pop_front(); compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL norm_ee_ignored: got %h expected %h", got, exp); end
`endif
    endtask

    initial begin
        compared       = 0;
        mismatched     = 0;
        reset_n        = 1'b0;
        bus_write      = 1'b0;
        bus_read       = 1'b0;
        bus_address_in = 24'h0;
        bus_data_in    = 8'h00;
        vid_page       = 4'd0;
        vid_column     = 8'd0;
        test_reset;
        test_write_basic;
        test_saturate;
        test_dropped_page;
        test_contrast;
        test_modes;
        test_read_latch;
        test_soft_reset;
        test_reset_mid_command;
        test_collision;
        test_rmw;
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
